// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite layer: pixel struct, ROM word
// width, ROM address width helper and the position handshake states.
package sprite_pkg;

  localparam int PIX_DEPTH = 4;
  localparam int ROM_W     = 3 * PIX_DEPTH + 1;

  typedef struct packed {
    logic                 a;
    logic [PIX_DEPTH-1:0] r;
    logic [PIX_DEPTH-1:0] g;
    logic [PIX_DEPTH-1:0] b;
  } pixel_t;

  typedef enum logic {
    IDLE,
    ACKED
  } hs_state_t;

  function automatic int addr_width(input int frames, input int spr_w, input int spr_h);
    return $clog2(frames * spr_w * spr_h);
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation counter: divides frame_start pulses by ANIM_DIV and steps a
// wrapping frame index once per division period.
module sprite_anim_ctr #(
  parameter int ANIM_DIV = 8,
  parameter int FRAMES   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  output logic [$clog2(FRAMES)-1:0] frame_idx
);

  localparam int FB    = $clog2(FRAMES);
  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;

  // Count video frames and advance the animation frame when the divider wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      frame_idx <= '0;
    end else if (frame_start) begin
      if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
        div_cnt   <= '0;
        frame_idx <= (frame_idx == FB'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_layer.sv
// Sprite layer: hit-tests the scan position against one animated sprite,
// fetches the texel from an external synchronous ROM and emits RGBA with
// a fixed 3-clock latency. Position updates arrive via req/ack and are
// committed only on frame_start. Optional macro SPRITE_MIRROR_EN adds a
// mirror_req input giving a horizontal flip.
module sprite_layer
  import sprite_pkg::*;
#(
  parameter int DEPTH    = PIX_DEPTH,
  parameter int H_BITS   = 10,
  parameter int V_BITS   = 10,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [H_BITS-1:0]                           hcount,
  input  logic [V_BITS-1:0]                           vcount,
  input  logic                                        frame_start,
  input  logic [H_BITS-1:0]                           pos_x,
  input  logic [V_BITS-1:0]                           pos_y,
  input  logic                                        pos_req,
`ifdef SPRITE_MIRROR_EN
  input  logic                                        mirror_req,
`endif
  output logic                                        pos_ack,
  output logic [addr_width(FRAMES, SPR_W, SPR_H)-1:0] rom_addr,
  input  logic [3*DEPTH:0]                            rom_data,
  output logic [DEPTH-1:0]                            R_curr,
  output logic [DEPTH-1:0]                            G_curr,
  output logic [DEPTH-1:0]                            B_curr,
  output logic                                        A_curr
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam int FB = $clog2(FRAMES);

  hs_state_t         state, state_nxt;
  logic              ack_nxt;
  logic              capture;
  logic              pending;
  logic [H_BITS-1:0] shd_x, act_x;
  logic [V_BITS-1:0] shd_y, act_y;
`ifdef SPRITE_MIRROR_EN
  logic              shd_m, act_m;
`endif
  logic [FB-1:0]     frame_idx;
  logic [H_BITS:0]   dx;
  logic [V_BITS:0]   dy;
  logic              hit;
  logic [XB-1:0]     col;
  logic              hit_d1, hit_d2;
  pixel_t            pix;

  sprite_anim_ctr #(
    .ANIM_DIV (ANIM_DIV),
    .FRAMES   (FRAMES)
  ) u_anim (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_idx   (frame_idx)
  );

  // Handshake next state: ack a request once, then wait for req to drop
  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (pos_req) begin
          capture   = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = ACKED;
        end
      end
      ACKED: begin
        if (!pos_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake state register and registered one-cycle acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pos_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      pos_ack <= ack_nxt;
    end
  end

  // Shadow capture and frame-boundary commit; a same-cycle capture stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      shd_x   <= '0;
      shd_y   <= '0;
      act_x   <= '0;
      act_y   <= '0;
      pending <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      shd_m   <= 1'b0;
      act_m   <= 1'b0;
`endif
    end else begin
      if (frame_start && pending) begin
        act_x   <= shd_x;
        act_y   <= shd_y;
        pending <= 1'b0;
`ifdef SPRITE_MIRROR_EN
        act_m   <= shd_m;
`endif
      end
      if (capture) begin
        shd_x   <= pos_x;
        shd_y   <= pos_y;
        pending <= 1'b1;
`ifdef SPRITE_MIRROR_EN
        shd_m   <= mirror_req;
`endif
      end
    end
  end

  // Hit test with one extra bit so offsets never wrap across the screen edge
  always_comb begin
    dx  = {1'b0, hcount} - {1'b0, act_x};
    dy  = {1'b0, vcount} - {1'b0, act_y};
    hit = (hcount >= act_x) && (dx < (H_BITS+1)'(SPR_W)) &&
          (vcount >= act_y) && (dy < (V_BITS+1)'(SPR_H));
`ifdef SPRITE_MIRROR_EN
    col = act_m ? (XB'(SPR_W - 1) - dx[XB-1:0]) : dx[XB-1:0];
`else
    col = dx[XB-1:0];
`endif
  end

  // Three-stage pipeline: address, ROM read, output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      hit_d2   <= 1'b0;
      pix      <= '0;
    end else begin
      rom_addr <= hit ? {frame_idx, dy[YB-1:0], col} : '0;
      hit_d1   <= hit;
      hit_d2   <= hit_d1;
      pix      <= hit_d2 ? pixel_t'(rom_data) : '0;
    end
  end

  assign A_curr = pix.a;
  assign R_curr = pix.r;
  assign G_curr = pix.g;
  assign B_curr = pix.b;

endmodule

// File: doc/sprite_layer.md
Name: sprite_layer

Overview:
- Per-layer pixel source that drives the {R,G,B,A} "current" inputs of one compositor stage.
- From the scan position it decides whether the current pixel lies inside one animated sprite.
- It then fetches the texel from an external synchronous sprite ROM and emits an RGBA pixel with 1-bit alpha (transparent outside the sprite or where the ROM says so).
- Game logic updates sprite position via a req/ack handshake; updates take effect only at frame boundaries, so no tearing.

Parameters:
- DEPTH, 4, bits per colour channel.
- H_BITS, 10, width of hcount/pos_x.
- V_BITS, 10, width of vcount/pos_y.
- SPR_W, 32, sprite width in pixels (power of 2).
- SPR_H, 32, sprite height in pixels (power of 2).
- FRAMES, 4, animation frames stored in ROM (power of 2).
- ANIM_DIV, 8, video frames per animation step (≥1).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount  in  H_BITS  current scan column
- vcount  in  V_BITS  current scan row
- frame_start  in  1  one-cycle pulse at start of vblank
- pos_x  in  H_BITS  requested sprite left edge
- pos_y  in  V_BITS  requested sprite top edge
- pos_req  in  1  position update request (held until ack)
- pos_ack  out  1  one-cycle acknowledge
- rom_addr  out  log2(FRAMES*SPR_W*SPR_H)  sprite ROM address
- rom_data  in  3*DEPTH+1  {A,R,G,B} texel, valid 1 cycle after rom_addr
- R_curr, G_curr, B_curr  out  DEPTH each  pixel colour
- A_curr  out  1  pixel opaque flag

Behaviour:
- Reset: all outputs 0; active and shadow position 0; anim frame 0; anim divider 0; pending flag 0.
- Handshake state machine:
  - IDLE: on pos_req=1, capture pos_x/pos_y into the shadow registers, assert pos_ack for exactly one cycle, set pending, go to ACKED.
  - ACKED: stay until pos_req=0, then return to IDLE. A new request is never acked while pos_req remains high after the ack.
- Commit: on frame_start with pending=1, copy shadow to active and clear pending.
- frame_start and a capture in the same cycle: the commit uses the shadow value held before that cycle. The newly captured value stays pending and applies at the next frame_start.
- Animation:
  - Divider counts frame_start pulses 0..ANIM_DIV-1.
  - When it wraps, the anim frame increments modulo FRAMES (FRAMES-1 → 0).
- Hit test, cycle 0, on the registered inputs:
  - dx = hcount - act_x and dy = vcount - act_y, each computed with 1 extra bit.
  - hit = (hcount ≥ act_x) & (dx < SPR_W) & (vcount ≥ act_y) & (dy < SPR_H).
  - Comparisons are unsigned with no wrap-around: a sprite at act_x = 1020 shows only its columns 0..3 and never wraps to column 0 of the screen.
- Pipeline:
  - Cycle 1: rom_addr = frame*SPR_W*SPR_H + dy*SPR_W + dx is registered, and hit_d1 is registered. rom_addr = 0 when there is no hit.
  - Cycle 2: rom_data arrives; hit_d2 is registered.
  - Cycle 3: outputs are registered.
  - Fixed latency is 3 clocks from hcount/vcount to R/G/B/A_curr.
- Output rule:
  - If hit_d2 = 1: {A,R,G,B}_curr = rom_data.
  - Otherwise: all four outputs = 0.
  - Transparent texels (A = 0) pass their colour bits through unchanged; the compositor ignores them.
- Reset mid-frame: the pipeline flushes to 0 on the next edge, and the outputs are transparent for at least 3 cycles.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- With the macro defined:
  - Extra input mirror_req (1 bit) is captured with pos_x/pos_y into the shadow registers and committed the same way.
  - When the active mirror bit = 1, the column used is SPR_W-1-dx, giving a horizontal flip.
- Without the macro: no port, no logic; the column used is always dx.

Decomposition:
- Shared package sprite_pkg holds:
  - pixel_t struct {a, r, g, b};
  - ROM word width constant;
  - an addr-width function clog2(FRAMES*SPR_W*SPR_H);
  - handshake state enum {IDLE, ACKED}.
- Sub-module sprite_anim_ctr holds the frame_start divider plus the wrapping frame counter, with output frame index.

Test Plan:
- Reset, then scan with no request → all outputs 0 everywhere; pos_ack never asserts.
- pos_req with (100,50), held 5 cycles → pos_ack high exactly once, in the cycle after the request. Pixels stay transparent until frame_start; after it, hcount=100, vcount=50 gives rom_addr=0 one cycle later and output = ROM[0] three cycles after input.
- Active position (1020,0), scan hcount 1019..1023 → hit only at 1020..1023 (dx 0..3); hcount=0 of the next line is not hit.
- ANIM_DIV=2, FRAMES=4, 10 frame_start pulses → frame index sequence 0,0,1,1,2,2,3,3,0,0. The base address at pixel (act_x,act_y) is 0, 1024, 2048, 3072, 0.
- pos_req captured in the same cycle as frame_start → the old shadow is committed; the new position appears only after the second frame_start.
- With SPRITE_MIRROR_EN and mirror_req=1 committed, hcount=act_x → column 31 is addressed (rom_addr low bits 31); without the macro, column 0.
